// File: rtl/bus_sched_pkg.sv
// Shared types and widths for the bus round-robin scheduler.
package bus_sched_pkg;

  typedef enum logic [1:0] {IDLE, POP, DELIVER} sched_state_e;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 16;

endpackage

// File: rtl/bus_rr_scheduler_pick.sv
// Combinational rotating-priority encoder: grants the first request after ptr, wrapping mod N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  int idx;

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    // k = N revisits ptr itself, so a lone requester at ptr still wins.
    for (int k = 1; k <= N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin packet mover between terminal FIFOs: IDLE picks a source, POP consumes its head,
// DELIVER pushes to the decoded destination (or all others on broadcast). One packet per 3 cycles.
module bus_rr_scheduler
  import bus_sched_pkg::*;
#(
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [drvrs-1:0]                 pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]    D_pop,
  output logic [drvrs-1:0]                 pop,
  output logic [drvrs-1:0]                 push,
  output logic [drvrs-1:0][pckg_sz-1:0]    D_push,
  output logic                             busy,
  output logic [CNT_W-1:0]                 pkt_cnt,
  output logic [CNT_W-1:0]                 drop_cnt
);

  localparam int IW = $clog2(drvrs);

  sched_state_e                     state_q, state_d;
  logic [IW-1:0]                    src_q, src_d;
  logic [IW-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [pckg_sz-1:0]               pkt_q, pkt_d;
  logic [drvrs-1:0]                 pop_q, pop_d;
  logic [drvrs-1:0]                 push_q, push_d;
  logic [drvrs-1:0][pckg_sz-1:0]    dpush_q, dpush_d;
  logic                             busy_q, busy_d;
  logic [CNT_W-1:0]                 pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]                 drop_cnt_q, drop_cnt_d;

  logic [IW-1:0]                    gnt_idx;
  logic                             gnt_vld;
  logic [pckg_sz-1:0]               head;
  logic [ADDR_W-1:0]                dest;

  rr_pick #(.N(drvrs), .IW(IW)) u_pick (
    .req     (pndng),
    .ptr     (rr_ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Head of the selected FIFO is still valid throughout the POP cycle.
  assign head = D_pop[src_q];
  assign dest = head[pckg_sz-1 -: ADDR_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      src_q      <= '0;
      rr_ptr_q   <= IW'(drvrs - 1);
      pkt_q      <= '0;
      pop_q      <= '0;
      push_q     <= '0;
      dpush_q    <= '0;
      busy_q     <= 1'b0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      rr_ptr_q   <= rr_ptr_d;
      pkt_q      <= pkt_d;
      pop_q      <= pop_d;
      push_q     <= push_d;
      dpush_q    <= dpush_d;
      busy_q     <= busy_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = POP;
      POP:     state_d = DELIVER;
      DELIVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    src_d      = src_q;
    rr_ptr_d   = rr_ptr_q;
    pkt_d      = pkt_q;
    pop_d      = '0;
    push_d     = '0;
    dpush_d    = '0;
    busy_d     = (state_d != IDLE);
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          src_d          = gnt_idx;
          pop_d[gnt_idx] = 1'b1;
        end
      end
      POP: begin
        pkt_d = head;
        // Decode now so push is a registered output during DELIVER.
        for (int j = 0; j < drvrs; j++) begin
          if (j != int'(src_q) && (dest == broadcast || dest == ADDR_W'(j))) begin
            push_d[j]  = 1'b1;
            dpush_d[j] = head;
          end
        end
      end
      DELIVER: begin
        rr_ptr_d = src_q;
        if (|push_q) pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
        else         drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign D_push   = dpush_q;
  assign busy     = busy_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Directed bench for bus_rr_scheduler with drvrs=4, pckg_sz=16, broadcast=8'hFF.
module tb_bus_rr_scheduler;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        pndng;
  logic [3:0][15:0]  D_pop;
  logic [3:0]        pop;
  logic [3:0]        push;
  logic [3:0][15:0]  D_push;
  logic              busy;
  logic [15:0]       pkt_cnt;
  logic [15:0]       drop_cnt;

  int checks = 0;
  int errors = 0;

  bus_rr_scheduler #(.drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .busy     (busy),
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // One single-source transaction: expects pop then push mask, then counters.
  task automatic one_pkt(input string tag, input int src, input logic [15:0] pkt,
                         input logic [3:0] exp_push, input logic [15:0] exp_pkt,
                         input logic [15:0] exp_drop);
    D_pop[src] = pkt;
    pndng      = 4'b0001 << src;
    step();
    check({tag, "_pop"}, pop, 4'b0001 << src);
    check({tag, "_busy"}, busy, 1);
    pndng = 4'b0000;
    step();
    check({tag, "_nopop"}, pop, 0);
    check({tag, "_push"}, push, exp_push);
    for (int j = 0; j < 4; j++)
      if (exp_push[j]) check({tag, "_dpush"}, D_push[j], pkt);
    step();
    check({tag, "_idle_push"}, push, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_pkt_cnt"}, pkt_cnt, exp_pkt);
    check({tag, "_drop_cnt"}, drop_cnt, exp_drop);
  endtask

  initial begin
    pndng = '0;
    D_pop = '0;
    do_reset();
    check("rst_pop", pop, 0);
    check("rst_push", push, 0);
    check("rst_dpush", D_push[2], 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);

    // Unicast 0 -> 2
    one_pkt("uni", 0, 16'h0255, 4'b0100, 16'd1, 16'd0);

    // Round robin from a fresh reset: src i sends to (i+1)%4
    do_reset();
    for (int i = 0; i < 4; i++) D_pop[i] = {8'((i + 1) % 4), 8'(8'hA0 + i)};
    pndng = 4'b1111;
    for (int p = 0; p < 8; p++) begin
      step();
      check("rr_pop", pop, 4'b0001 << (p % 4));
      if (p == 7) pndng = 4'b0000;
      step();
      check("rr_gap1_pop", pop, 0);
      check("rr_push", push, 4'b0001 << ((p + 1) % 4));
      step();
      check("rr_gap2_pop", pop, 0);
      check("rr_gap2_push", push, 0);
    end
    check("rr_pkt_cnt", pkt_cnt, 8);

    // Broadcast from src 1
    one_pkt("bcast", 1, 16'hFF3C, 4'b1101, 16'd9, 16'd0);

    // Invalid destination, then destination equal to source
    one_pkt("bad_dest", 0, 16'h0711, 4'b0000, 16'd9, 16'd1);
    one_pkt("self_dest", 0, 16'h0099, 4'b0000, 16'd9, 16'd2);

    // Reset while pop is asserted
    D_pop[2] = 16'h0133;
    pndng    = 4'b0100;
    step();
    check("rstpop_pop", pop, 4'b0100);
    reset = 1'b1;
    pndng = 4'b0000;
    #1;
    check("rstpop_pop_clr", pop, 0);
    check("rstpop_busy", busy, 0);
    check("rstpop_drop_cnt", drop_cnt, 0);
    step();
    check("rstpop_nopush", push, 0);
    D_pop[0] = 16'h0322;
    D_pop[3] = 16'h0044;
    pndng    = 4'b1001;
    reset    = 1'b0;
    step();
    check("rstpop_grant0", pop, 4'b0001);
    pndng = 4'b0000;
    step();
    check("rstpop_push", push, 4'b1000);
    step();
    check("rstpop_pkt_cnt", pkt_cnt, 1);

    // Counter wrap: preload pkt_cnt to its maximum, then one delivery
    force dut.pkt_cnt_q = 16'hFFFF;
    #1;
    release dut.pkt_cnt_q;
    check("wrap_preload", pkt_cnt, 16'hFFFF);
    one_pkt("wrap", 1, 16'h0200, 4'b0100, 16'd0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
